onchip_ram_avmm: RTL and testbench

Parametrised single-port on-chip RAM with an Avalon-MM slave interface. It replaces the fixed 2048×16 on-chip memory slave. Width, depth and read latency are configurable. It adds explicit `read`, `waitrequest` and `readdatavalid` handshakes, plus an optional zero-fill of the whole array after reset. It sits on the HPS-side interconnect as a scratch/shared buffer.

---
 rtl/onchip_ram_pkg.sv | 25 ++
 rtl/onchip_ram_core.sv | 60 ++++++
 rtl/onchip_ram_avmm.sv | 188 ++++++++++++++++++
 tb/tb_onchip_ram_avmm.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_ram_pkg.sv
// Shared types and helpers for the Avalon-MM on-chip RAM.
// ONCHIP_RAM_PARITY_EN adds one even-parity bit per stored byte.
package onchip_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } clr_state_e;

  localparam int MAX_READ_LATENCY = 4;

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

  // Parity bits sit above the data bits, one per byte lane.
  function automatic int storage_width(input int data_w);
`ifdef ONCHIP_RAM_PARITY_EN
    return data_w + data_w / 8;
`else
    return data_w;
`endif
  endfunction

endpackage

// File: rtl/onchip_ram_core.sv
// Byte-enabled single-port storage array with a registered, read-before-write output.
// With ONCHIP_RAM_PARITY_EN each byte lane also owns its parity bit at DATA_W+lane.
module onchip_ram_core
  import onchip_ram_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 11,
  parameter int STORE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                we,
  input  logic                re,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [STORE_W-1:0]  wdata,
  output logic [STORE_W-1:0]  rdata
);

  localparam int NB = DATA_W / 8;

  logic [STORE_W-1:0] mem [2**ADDR_W];
  logic [STORE_W-1:0] rdata_q;
  logic [STORE_W-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (en && re) begin
      rdata_d = mem[addr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
`ifdef ONCHIP_RAM_PARITY_EN
          mem[addr][DATA_W+i] <= wdata[DATA_W+i];
`endif
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/onchip_ram_avmm.sv
// Avalon-MM slave wrapper: handshakes, post-reset clear sweep and read latency stages.
// Define ONCHIP_RAM_PARITY_EN for per-byte parity storage and the s1_parityerr output.
module onchip_ram_avmm
  import onchip_ram_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 11,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W-1:0]   s1_writedata,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic                s1_clken,
  output logic                s1_waitrequest,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid
`ifdef ONCHIP_RAM_PARITY_EN
  ,
  output logic                s1_parityerr
`endif
);

  localparam int NB      = DATA_W / 8;
  localparam int STORE_W = storage_width(DATA_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  clr_state_e                            state_q;
  logic [ADDR_W-1:0]                     clr_addr_q;
  logic                                  clearing_s;
  logic                                  accept_s;
  logic [STORE_W-1:0]                    enc_wdata_s;
  logic [ADDR_W-1:0]                     mem_addr_s;
  logic [NB-1:0]                         mem_be_s;
  logic [STORE_W-1:0]                    mem_wdata_s;
  logic                                  mem_we_s;
  logic                                  mem_re_s;
  logic [STORE_W-1:0]                    core_rdata_s;
  logic [READ_LATENCY-1:0]               valid_q;
  logic [READ_LATENCY-1:0]               valid_d;
  logic [READ_LATENCY-1:0][STORE_W-1:0]  stage_data_s;
  logic [STORE_W-1:0]                    last_s;

  assign clearing_s     = (state_q == CLEAR);
  assign s1_waitrequest = reset_reset | clearing_s | ~s1_clken;
  assign accept_s       = s1_chipselect & (s1_read | s1_write) & ~s1_waitrequest;

  always_comb begin
    enc_wdata_s = '0;
    enc_wdata_s[DATA_W-1:0] = s1_writedata;
`ifdef ONCHIP_RAM_PARITY_EN
    for (int i = 0; i < NB; i++) begin
      enc_wdata_s[DATA_W+i] = byte_parity(s1_writedata[8*i +: 8]);
    end
`endif
  end

  // The clear sweep owns the port; an all-zero word carries even parity 0.
  always_comb begin
    mem_addr_s  = s1_address;
    mem_be_s    = s1_byteenable;
    mem_wdata_s = enc_wdata_s;
    mem_we_s    = accept_s & s1_write;
    mem_re_s    = accept_s & s1_read & ~s1_write;
    if (clearing_s) begin
      mem_addr_s  = clr_addr_q;
      mem_be_s    = {NB{1'b1}};
      mem_wdata_s = '0;
      mem_we_s    = ~reset_reset;
      mem_re_s    = 1'b0;
    end else begin
      mem_addr_s  = s1_address;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q    <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_addr_q <= '0;
    end else if (s1_clken) begin
      case (state_q)
        CLEAR: begin
          if (clr_addr_q == LAST_ADDR) begin
            state_q <= READY;
          end else begin
            state_q <= CLEAR;
          end
          clr_addr_q <= clr_addr_q + 1'b1;
        end
        READY:   state_q <= READY;
        default: state_q <= READY;
      endcase
    end else begin
      state_q <= state_q;
    end
  end

  onchip_ram_core #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .STORE_W (STORE_W)
  ) u_core (
    .clk   (clk_clk),
    .rst   (reset_reset),
    .en    (s1_clken),
    .we    (mem_we_s),
    .re    (mem_re_s),
    .addr  (mem_addr_s),
    .be    (mem_be_s),
    .wdata (mem_wdata_s),
    .rdata (core_rdata_s)
  );

  always_comb begin
    valid_d = valid_q;
    if (s1_clken) begin
      valid_d[0] = mem_re_s;
      for (int k = 1; k < READ_LATENCY; k++) begin
        valid_d[k] = valid_q[k-1];
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Reset drops any in-flight beats.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign stage_data_s[0] = core_rdata_s;

  for (genvar k = 1; k < READ_LATENCY; k++) begin : g_stage
    logic [STORE_W-1:0] data_q;
    logic [STORE_W-1:0] data_d;

    always_comb begin
      data_d = data_q;
      if (s1_clken) begin
        data_d = stage_data_s[k-1];
      end else begin
        data_d = data_q;
      end
    end

    // One extra latency stage; holds while the clock enable is low.
    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        data_q <= '0;
      end else begin
        data_q <= data_d;
      end
    end

    assign stage_data_s[k] = data_q;
  end

  assign last_s           = stage_data_s[READ_LATENCY-1];
  assign s1_readdata      = last_s[DATA_W-1:0];
  assign s1_readdatavalid = valid_q[READ_LATENCY-1] & s1_clken;

`ifdef ONCHIP_RAM_PARITY_EN
  logic par_mismatch_s;

  always_comb begin
    par_mismatch_s = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (byte_parity(last_s[8*i +: 8]) != last_s[DATA_W+i]) begin
        par_mismatch_s = 1'b1;
      end else begin
        par_mismatch_s = par_mismatch_s;
      end
    end
  end

  assign s1_parityerr = s1_readdatavalid & par_mismatch_s;
`endif

endmodule

// File: tb/tb_onchip_ram_avmm.sv
// Self-checking bench for onchip_ram_avmm: directed tables, corner sequences and a
// randomized phase checked against an array/queue model of the Avalon-MM behaviour.
module tb_onchip_ram_avmm;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int RL    = 2;
  localparam int DEPTH = 16;
`ifdef ONCHIP_RAM_PARITY_EN
  localparam int SW = DW + DW / 8;
`else
  localparam int SW = DW;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic          cs;
  logic          rd;
  logic          wr;
  logic [DW-1:0] wdata;
  logic [1:0]    be;
  logic          clken;
  logic          wreq;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          perr_w;

  always #5 clk = ~clk;

  onchip_ram_avmm #(
    .DATA_W         (DW),
    .ADDR_W         (AW),
    .READ_LATENCY   (RL),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk_clk          (clk),
    .reset_reset      (rst),
    .s1_address       (addr),
    .s1_chipselect    (cs),
    .s1_read          (rd),
    .s1_write         (wr),
    .s1_writedata     (wdata),
    .s1_byteenable    (be),
    .s1_clken         (clken),
    .s1_waitrequest   (wreq),
    .s1_readdata      (rdata),
    .s1_readdatavalid (rvalid)
`ifdef ONCHIP_RAM_PARITY_EN
    ,
    .s1_parityerr     (perr_w)
`endif
  );

`ifndef ONCHIP_RAM_PARITY_EN
  assign perr_w = 1'b0;
`endif

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] init;
    logic [DW-1:0] wd;
    logic [1:0]    be;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } beat_t;

  int            total = 0;
  int            bad   = 0;
  int            n;
  int            lat;
  int            en_cnt;
  int            cnt;
  logic [DW-1:0] d;
  logic          pe;
  logic          exp_v;
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] pv [4];
  vec_t          tbl [6];
  beat_t         q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [SW-1:0] mk(input logic [DW-1:0] v);
    logic [SW-1:0] w;
    w = '0;
    w[DW-1:0] = v;
`ifdef ONCHIP_RAM_PARITY_EN
    for (int i = 0; i < DW / 8; i++) w[DW+i] = ^v[8*i +: 8];
`endif
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cs = 1'b0;
    rd = 1'b0;
    wr = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Counts waitrequest-high cycles; returns at the first low cycle (mid-cycle).
  task automatic count_wait(output int nw);
    bit done;
    nw   = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!wreq) begin
        done = 1'b1;
      end else begin
        nw++;
        step();
      end
    end
  endtask

  task automatic wr_word(input logic [AW-1:0] a, input logic [DW-1:0] v, input logic [1:0] b);
    addr  = a;
    wdata = v;
    be    = b;
    cs    = 1'b1;
    wr    = 1'b1;
    rd    = 1'b0;
    step();
    idle();
  endtask

  task automatic rd_word(input logic [AW-1:0] a, output logic [DW-1:0] v,
                         output int l, output logic p);
    bit found;
    addr  = a;
    cs    = 1'b1;
    rd    = 1'b1;
    wr    = 1'b0;
    step();
    idle();
    v     = '0;
    p     = 1'b0;
    l     = -1;
    found = 1'b0;
    for (int c = 1; c <= 10 && !found; c++) begin
      @(negedge clk);
      if (rvalid) begin
        v     = rdata;
        p     = perr_w;
        l     = c;
        found = 1'b1;
      end
      step();
    end
  endtask

  task automatic stall_seq(input int s0, input string tag);
    wr_word(4'd9, 16'h5A5A, 2'b11);
    for (int c = 0; c < 10; c++) begin
      clken = !(c == s0 || c == s0 + 1);
      if (c == 0) begin
        cs   = 1'b1;
        rd   = 1'b1;
        addr = 4'd9;
      end else begin
        idle();
      end
      @(negedge clk);
      if (!clken) chk({tag, "_waitreq"}, wreq, 1);
      chk({tag, "_valid"}, rvalid, (c == RL + 2));
      if (c == RL + 2) chk({tag, "_data"}, rdata, 16'h5A5A);
      step();
    end
    clken = 1'b1;
  endtask

  initial begin
    tbl[0] = '{4'd3,  16'h1234, 16'hABCD, 2'b10, 16'hAB34};
    tbl[1] = '{4'd4,  16'h1234, 16'hABCD, 2'b01, 16'h12CD};
    tbl[2] = '{4'd5,  16'h1234, 16'hABCD, 2'b11, 16'hABCD};
    tbl[3] = '{4'd6,  16'h1234, 16'hABCD, 2'b00, 16'h1234};
    tbl[4] = '{4'd0,  16'hFFFF, 16'h0000, 2'b01, 16'hFF00};
    tbl[5] = '{4'd15, 16'h0000, 16'h5AA5, 2'b10, 16'h5A00};
    pv[0] = 16'h0F01;
    pv[1] = 16'h1E12;
    pv[2] = 16'h2D23;
    pv[3] = 16'h3C34;

    rst   = 1'b1;
    clken = 1'b1;
    addr  = '0;
    wdata = '0;
    be    = '0;
    idle();
    step();
    @(negedge clk);
    chk("reset_waitreq", wreq, 1);
    chk("reset_valid", rvalid, 0);
    chk("reset_rdata", rdata, 0);
`ifdef ONCHIP_RAM_PARITY_EN
    chk("reset_perr", perr_w, 0);
`endif
    step();
    rst = 1'b0;
    count_wait(n);
    chk("init_clear_wait", n, 16);

    // Clear after reset over a fully preloaded array.
    for (int i = 0; i < DEPTH; i++) dut.u_core.mem[i] = mk(16'hFFFF);
    pulse_reset();
    count_wait(n);
    chk("clear_wait_cycles", n, 16);
    for (int i = 0; i < DEPTH; i++) begin
      rd_word(4'(i), d, lat, pe);
      chk("clear_read", d, 0);
      chk("clear_latency", lat, RL);
    end

    // Byte-enable table.
    for (int i = 0; i < 6; i++) begin
      wr_word(tbl[i].a, tbl[i].init, 2'b11);
      wr_word(tbl[i].a, tbl[i].wd, tbl[i].be);
      rd_word(tbl[i].a, d, lat, pe);
      chk("tbl_data", d, tbl[i].exp);
      chk("tbl_latency", lat, RL);
    end

    // Back-to-back reads.
    for (int i = 0; i < 4; i++) wr_word(4'(i), pv[i], 2'b11);
    for (int c = 0; c < 12; c++) begin
      if (c < 4) begin
        cs   = 1'b1;
        rd   = 1'b1;
        wr   = 1'b0;
        addr = 4'(c);
      end else begin
        idle();
      end
      @(negedge clk);
      exp_v = (c >= RL && c < RL + 4);
      chk("pipe_valid", rvalid, exp_v);
      if (exp_v) chk("pipe_data", rdata, pv[c-RL]);
      step();
    end

    // clken stalls with the beat in the first stage, then in the last stage.
    stall_seq(1, "stall_early");
    stall_seq(RL, "stall_late");

    // Reset while the sweep is at address 7 restarts it at 0.
    pulse_reset();
    for (int k = 0; k < 7; k++) step();
    dut.u_core.mem[0] = mk(16'hFFFF);
    dut.u_core.mem[3] = mk(16'hFFFF);
    pulse_reset();
    count_wait(n);
    chk("midclear_wait_cycles", n, 16);
    rd_word(4'd0, d, lat, pe);
    chk("midclear_addr0", d, 0);
    rd_word(4'd3, d, lat, pe);
    chk("midclear_addr3", d, 0);
    rd_word(4'd7, d, lat, pe);
    chk("midclear_addr7", d, 0);

    // Reset with a read in flight.
    wr_word(4'd5, 16'hC3C3, 2'b11);
    addr = 4'd5;
    cs   = 1'b1;
    rd   = 1'b1;
    step();
    idle();
    pulse_reset();
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rvalid) cnt++;
      step();
    end
    chk("flush_valid_count", cnt, 0);

`ifdef ONCHIP_RAM_PARITY_EN
    wr_word(4'd5, 16'h3C3C, 2'b11);
    wr_word(4'd6, 16'h1234, 2'b11);
    dut.u_core.mem[5][0] = ~dut.u_core.mem[5][0];
    rd_word(4'd5, d, lat, pe);
    chk("parity_err_set", pe, 1);
    rd_word(4'd6, d, lat, pe);
    chk("parity_clean", pe, 0);
    chk("parity_clean_data", d, 16'h1234);
`endif

    // Randomized traffic against the model.
    pulse_reset();
    count_wait(n);
    chk("rand_clear_wait", n, 16);
    step();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    en_cnt = 0;
    q.delete();
    for (int it = 0; it < 600 + RL + 3; it++) begin
      if (it < 600) begin
        clken = ($urandom_range(0, 5) != 0);
        cs    = ($urandom_range(0, 3) != 0);
        rd    = 1'($urandom_range(0, 1));
        wr    = 1'($urandom_range(0, 1));
        addr  = 4'($urandom_range(0, 15));
        wdata = 16'($urandom);
        be    = 2'($urandom_range(0, 3));
      end else begin
        clken = 1'b1;
        idle();
      end
      @(negedge clk);
      chk("rand_waitreq", wreq, !clken);
      exp_v = (q.size() > 0) && (q[0].due == en_cnt) && clken;
      chk("rand_valid", rvalid, exp_v);
      if (exp_v) begin
        chk("rand_rdata", rdata, q[0].d);
        void'(q.pop_front());
      end
      @(posedge clk);
      if (clken) begin
        en_cnt++;
        if (cs && (rd || wr)) begin
          if (wr) begin
            for (int b = 0; b < 2; b++) if (be[b]) mem_m[addr][8*b +: 8] = wdata[8*b +: 8];
          end else begin
            q.push_back('{d: mem_m[addr], due: en_cnt + RL - 1});
          end
        end
      end
      #1;
    end
    chk("rand_queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
